// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Shared types and constants for the pipelined FP32 add/subtract unit.
//   fp32_t : IEEE-754 single-precision field view {sign, exp, frac}
//   s1_t   : payload captured after unpack/align
//   s2_t   : payload captured after the mantissa add
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam int unsigned MANT_W  = 24;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam fp32_t FP32_PINF  = 32'h7F80_0000;
    localparam fp32_t FP32_NINF  = 32'hFF80_0000;
    localparam fp32_t FP32_ZERO  = 32'h0000_0000;
    localparam fp32_t FP32_NZERO = 32'h8000_0000;

    // After alignment: the larger-exponent operand and the already shifted
    // smaller mantissa, plus a fully resolved result when a special case hit.
    typedef struct packed {
        logic              isSpecial;
        fp32_t             specRes;
        logic              signL;
        logic              signS;
        logic [7:0]        expL;
        logic [MANT_W-1:0] mantL;
        logic [MANT_W-1:0] mantS;
    } s1_t;

    // After the add: sign-magnitude sum with its carry bit at mag[MANT_W].
    typedef struct packed {
        logic            isSpecial;
        fp32_t           specRes;
        logic            sign;
        logic [7:0]      exp;
        logic [MANT_W:0] mag;
    } s2_t;

    function automatic logic fp32IsNan(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac != '0);
    endfunction

    function automatic logic fp32IsInf(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac == '0);
    endfunction

endpackage

// File: rtl/fp_lzc25.sv
// -----------------------------------------------------------------------------
// fp_lzc25
// Combinational leading-zero counter over a 25-bit magnitude.
//   value_i [24:0] : magnitude to scan (bit 24 is the MSB)
//   count_o [4:0]  : number of zeros above the leading one, 25 when all zero
// -----------------------------------------------------------------------------
module fp_lzc25
    import fp32_pkg::*;
(
    input  logic [MANT_W:0] value_i,
    output logic [4:0]      count_o
);

    // Scanning upward lets the highest set bit write last, which makes this a
    // priority encoder on the leading one.
    always_comb begin
        count_o = 5'd25;
        for (int i = 0; i <= MANT_W; i++) begin
            if (value_i[i]) begin
                count_o = 5'(MANT_W - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe
// Three-stage IEEE-754 single-precision add/subtract with valid/ready flow
// control. A - B is computed as A + (-B). Truncating, no rounding.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset, clears all in-flight ops
//   in_valid_i   : operands present          in_ready_o  : unit can accept
//   op_sub_i     : 0 add, 1 subtract
//   dataA_i      : operand A                 dataB_i     : operand B
//   res_valid_o  : dataR_o holds a result    res_ready_i : consumer takes it
//   dataR_o      : result                    res_flags_o : {nan,inf,zero,ovf}
// -----------------------------------------------------------------------------
module fp_addsub_pipe
    import fp32_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE    = 32'hFFFF_FFFF,
    parameter bit          FLUSH_DENORM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        op_sub_i,
    input  logic [31:0] dataA_i,
    input  logic [31:0] dataB_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] dataR_o,
    output logic [3:0]  res_flags_o
);

    logic advance;

    fp32_t             opA, opB;
    logic              aNan, bNan, aInf, bInf, aZero, bZero;
    logic [7:0]        aExp, bExp, expDiff;
    logic [MANT_W-1:0] aMant, bMant, mantSmall;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic s1Valid_q, s2Valid_q, resValid_q;

    logic [MANT_W+1:0] sumD;

    logic [4:0]        lzCount, normShift;
    logic [22:0]       fracNorm, fracOut;
    logic signed [9:0] expNorm;
    fp32_t             res3;
    logic              ovf3;
    logic [3:0]        flags3;

    fp32_t       dataR_q;
    logic [3:0]  flags_q;

    // The whole pipeline moves as one; a held result stalls every stage.
    assign advance     = !resValid_q || res_ready_i;
    assign in_ready_o  = advance;
    assign res_valid_o = resValid_q;
    assign dataR_o     = dataR_q;
    assign res_flags_o = flags_q;

    // Unpack both operands with B already carrying its effective sign.
    // Denormals either flush to signed zero or run with exponent 1 and no
    // hidden bit.
    always_comb begin
        opA   = dataA_i;
        opB   = {dataB_i[31] ^ op_sub_i, dataB_i[30:0]};
        aNan  = fp32IsNan(opA);
        bNan  = fp32IsNan(opB);
        aInf  = fp32IsInf(opA);
        bInf  = fp32IsInf(opB);
        aZero = (opA.exp == 8'h00) && (FLUSH_DENORM || (opA.frac == '0));
        bZero = (opB.exp == 8'h00) && (FLUSH_DENORM || (opB.frac == '0));
        aExp  = (opA.exp == 8'h00) ? 8'd1 : opA.exp;
        bExp  = (opB.exp == 8'h00) ? 8'd1 : opB.exp;
        aMant = {(opA.exp != 8'h00), opA.frac};
        bMant = {(opB.exp != 8'h00), opB.frac};
    end

    // Stage 1: special-case decode in priority order, then align the smaller
    // operand. With equal exponents A is taken as "larger"; the signed add in
    // stage 2 fixes up the sign whichever way round they are.
    always_comb begin
        s1_d      = '0;
        expDiff   = '0;
        mantSmall = '0;

        if (aNan || bNan) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = NAN_VALUE;
        end else if (aInf && bInf && (opA.sign != opB.sign)) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = NAN_VALUE;
        end else if (aInf) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = opA.sign ? FP32_NINF : FP32_PINF;
        end else if (bInf) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = opB.sign ? FP32_NINF : FP32_PINF;
        end else if (({opA.exp, opA.frac} == {opB.exp, opB.frac}) &&
                     (opA.sign != opB.sign)) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = FP32_ZERO;
        end else if (aZero && bZero) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = (opA.sign && opB.sign) ? FP32_NZERO : FP32_ZERO;
        end else if (bZero) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = opA;
        end else if (aZero) begin
            s1_d.isSpecial = 1'b1;
            s1_d.specRes   = opB;
        end

        if (aExp >= bExp) begin
            s1_d.signL = opA.sign;
            s1_d.signS = opB.sign;
            s1_d.expL  = aExp;
            s1_d.mantL = aMant;
            expDiff    = aExp - bExp;
            mantSmall  = bMant;
        end else begin
            s1_d.signL = opB.sign;
            s1_d.signS = opA.sign;
            s1_d.expL  = bExp;
            s1_d.mantL = bMant;
            expDiff    = bExp - aExp;
            mantSmall  = aMant;
        end

        s1_d.mantS = (expDiff >= 8'd26) ? '0 : (mantSmall >> expDiff);
    end

    // Stage 2: like signs add magnitudes; unlike signs use a 26-bit two's
    // complement sum whose sign bit becomes the result sign.
    always_comb begin
        s2_d           = '0;
        sumD           = '0;
        s2_d.isSpecial = s1_q.isSpecial;
        s2_d.specRes   = s1_q.specRes;
        s2_d.exp       = s1_q.expL;

        if (s1_q.signL == s1_q.signS) begin
            s2_d.sign = s1_q.signL;
            s2_d.mag  = {1'b0, s1_q.mantL} + {1'b0, s1_q.mantS};
        end else begin
            sumD = (s1_q.signL ? -{2'b00, s1_q.mantL} : {2'b00, s1_q.mantL})
                 + (s1_q.signS ? -{2'b00, s1_q.mantS} : {2'b00, s1_q.mantS});
            s2_d.sign = sumD[MANT_W+1];
            s2_d.mag  = (MANT_W+1)'(sumD[MANT_W+1] ? -sumD : sumD);
        end
    end

    fp_lzc25 u_lzc (
        .value_i (s2_q.mag),
        .count_o (lzCount)
    );

    // Stage 3: a carry moves the binary point up one; otherwise shift the
    // leading one up to the hidden-bit position. Bits that fall off are
    // simply truncated.
    always_comb begin
        normShift = lzCount - 5'd1;
        fracNorm  = 23'(s2_q.mag << normShift);
        expNorm   = '0;
        fracOut   = '0;
        res3      = FP32_ZERO;
        ovf3      = 1'b0;

        if (s2_q.isSpecial) begin
            res3 = s2_q.specRes;
        end else if (s2_q.mag != '0) begin
            if (s2_q.mag[MANT_W]) begin
                expNorm = $signed({2'b00, s2_q.exp}) + 10'sd1;
                fracOut = s2_q.mag[MANT_W-1:1];
            end else begin
                expNorm = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, normShift});
                fracOut = fracNorm;
            end

            if (expNorm >= 10'sd255) begin
                res3 = s2_q.sign ? FP32_NINF : FP32_PINF;
                ovf3 = 1'b1;
            end else if (expNorm <= 10'sd0) begin
                res3 = FP32_ZERO;
            end else begin
                res3 = {s2_q.sign, expNorm[7:0], fracOut};
            end
        end

        flags3 = {fp32IsNan(res3), fp32IsInf(res3), ({res3.exp, res3.frac} == '0), ovf3};
    end

    // Stage registers. The output register only loads on a real result so
    // dataR_o and res_flags_o never change while a result is being held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            resValid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            dataR_q    <= FP32_ZERO;
            flags_q    <= 4'h0;
        end else if (advance) begin
            s1Valid_q  <= in_valid_i;
            s1_q       <= s1_d;
            s2Valid_q  <= s1Valid_q;
            s2_q       <= s2_d;
            resValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                dataR_q <= res3;
                flags_q <= flags3;
            end
        end
    end

endmodule
